codificador_botones: RTL and testbench
======================================

Name: codificador_botones

Overview:
- Writer side of the button-command buffer: turns the five raw push-buttons into the 3-bit movement codes consumed by the snake state machine.
- Codes: 0 nada, 1 arriba, 2 abajo, 3 izquierda, 4 derecha, 5 pausa.
- Synchronises and debounces each button, detects presses, and priority-encodes simultaneous presses.
- Pushes each code into a small show-ahead FIFO that the state machine pops with a read strobe; an empty FIFO reads as code 0.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable synchroniser samples required before a debounced level changes (>=2)
DEPTH, 4, FIFO entries (power of two, >=2)
SUPRIMIR_REPETIDOS, 1, when 1 drop a press whose code equals the newest stored entry while the FIFO is non-empty

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous active-low reset (0 = reset)
arriba  input  1  raw button, asynchronous, active-high
abajo  input  1  raw button
izquierda  input  1  raw button
derecha  input  1  raw button
pausa  input  1  raw button
rd_en  input  1  pop strobe from the state machine; one entry per high cycle
cmd  output  3  FIFO head; 3'd0 when empty (combinational from head/empty)
cmd_valid  output  1  FIFO non-empty
full  output  1  count == DEPTH
overflow  output  1  sticky: a press was lost to a full FIFO

Behaviour:
- Reset (rst=0, async):
  - sync flops, debounced levels, counters, FIFO pointers and count all 0.
  - cmd=0, cmd_valid=0, full=0, overflow=0.
- Synchroniser: 2 flops per button; s = stage-2 output.
- Debouncer, per button:
  - cnt increments while s != db, and clears whenever s == db.
  - When s != db and cnt == DEBOUNCE_CYCLES-1: db <= s, cnt <= 0.
  - Result: db changes at edge 2+DEBOUNCE_CYCLES after the raw input changes and then stays stable.
- Press event: asserted in the clock cycle where db goes 0->1; releases generate nothing.
- Priority when several presses occur in the same cycle: pausa > arriba > abajo > izquierda > derecha. Only the winner is written; the others are discarded (not overflow).
- Write, evaluated on the same edge that sets db:
  - Drop if SUPRIMIR_REPETIDOS=1, count>0 and the code equals the newest entry.
  - Else if full and no pop this cycle: drop and set overflow=1.
  - Else store at wr_ptr, wr_ptr++, count++.
- Read: rd_en=1 and count>0 -> rd_ptr++, count--.
  - rd_en while empty is ignored; no underflow and pointers do not move.
- Simultaneous push and pop:
  - Not full: count unchanged, both pointers advance.
  - Full: pop frees a slot, so the write is accepted and overflow is not set.
  - Empty: the pop is ignored and the write lands.
- Pointers wrap modulo DEPTH.
- overflow clears only on reset.
- Button held through reset release: db=0 after reset, so a press is generated once it has been stable DEBOUNCE_CYCLES cycles.
- Reset mid-debounce or mid-FIFO: immediate clear; in-flight presses and stored entries are lost.

Decomposition:
- Shared package: code constants CMD_NADA=0, CMD_ARRIBA=1, CMD_ABAJO=2, CMD_IZQUIERDA=3, CMD_DERECHA=4, CMD_PAUSA=5. The state machine includes the same package.
- Sub-module antirrebote (synchroniser + debouncer + rise pulse, parameter DEBOUNCE_CYCLES), instantiated 5 times.
- Priority encoder and FIFO stay inline.

Test Plan (DEBOUNCE_CYCLES=4, DEPTH=4 unless noted):
- Reset, then raise arriba before edge 0 and hold -> cmd_valid rises after edge 6, cmd=1; assert rd_en one cycle -> cmd=0, cmd_valid=0.
- Bounce derecha 1,0,1 with 2-cycle pulses, then hold high -> exactly one entry, code 4, written 6 edges after the final rise.
- Press abajo and pausa in the same cycle -> one entry, cmd=5; with SUPRIMIR_REPETIDOS=1 a second pausa press (no pop) -> count stays 1.
- SUPRIMIR_REPETIDOS=0, five presses 1,2,3,4,1 with no reads -> full=1 after the 4th, overflow=1 after the 5th; pops yield 1,2,3,4, then cmd=0.
- FIFO full, rd_en coincident with a new press of code 3 -> overflow stays 0, full stays 1; drain order is 2,3,4,3.
- Drop rst to 0 mid-debounce with 2 entries stored -> all outputs 0 immediately; hold izquierda through release -> one code-3 entry 6 edges after release.

Source files
------------

// File: rtl/codificador_botones_pkg.sv
// Movement codes shared by the button encoder and the snake state machine,
// plus the press priority used when several buttons fire in the same cycle.
package codificador_botones_pkg;

  localparam logic [2:0] CMD_NADA      = 3'd0;
  localparam logic [2:0] CMD_ARRIBA    = 3'd1;
  localparam logic [2:0] CMD_ABAJO     = 3'd2;
  localparam logic [2:0] CMD_IZQUIERDA = 3'd3;
  localparam logic [2:0] CMD_DERECHA   = 3'd4;
  localparam logic [2:0] CMD_PAUSA     = 3'd5;

  // p = {pausa, derecha, izquierda, abajo, arriba}; pausa always wins.
  function automatic logic [2:0] prioridad(input logic [4:0] p);
    if (p[4])      return CMD_PAUSA;
    else if (p[0]) return CMD_ARRIBA;
    else if (p[1]) return CMD_ABAJO;
    else if (p[2]) return CMD_IZQUIERDA;
    else if (p[3]) return CMD_DERECHA;
    else           return CMD_NADA;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Two-flop synchroniser and counting debouncer for one raw button; pulso is
// high in the cycle whose closing edge moves the debounced level 0->1.
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulso
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          nivel;
  logic          s;
  logic          flip;

  assign s     = sync[1];
  assign flip  = (s != nivel) && (cnt == LAST);
  assign pulso = flip && s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      cnt   <= '0;
      nivel <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (s == nivel) begin
        cnt <= '0;
      end else if (flip) begin
        nivel <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/codificador_botones.sv
// Debounces the five movement buttons, priority-encodes presses and queues
// the resulting codes in a show-ahead FIFO popped by the state machine.
module codificador_botones
  import codificador_botones_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 1000000,
  parameter int DEPTH              = 4,
  parameter bit SUPRIMIR_REPETIDOS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arriba,
  input  logic       abajo,
  input  logic       izquierda,
  input  logic       derecha,
  input  logic       pausa,
  input  logic       rd_en,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic       full,
  output logic       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  logic [4:0]    botones;
  logic [4:0]    pulsos;
  logic [2:0]    codigo;
  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [2:0]    newest;
  logic          do_pop;
  logic          repetido;
  logic          candidato;
  logic          do_push;

  assign botones = {pausa, derecha, izquierda, abajo, arriba};

  for (genvar i = 0; i < 5; i++) begin : g_ab
    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ab (
      .clk  (clk),
      .rst  (rst),
      .btn  (botones[i]),
      .pulso(pulsos[i])
    );
  end

  assign codigo = prioridad(pulsos);

  assign cmd_valid = (count != '0);
  assign full      = (count == DEPTH_C);
  assign cmd       = cmd_valid ? mem[rd_ptr] : CMD_NADA;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign newest    = mem[wr_ptr - PW'(1)];
  assign do_pop    = rd_en && cmd_valid;
  assign repetido  = SUPRIMIR_REPETIDOS && cmd_valid && (codigo == newest);
  assign candidato = (codigo != CMD_NADA) && !repetido;
  assign do_push   = candidato && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
      if (candidato && full && !do_pop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: cmd masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= codigo;
  end

endmodule

// File: tb/tb_codificador_botones.sv
// Bench for codificador_botones: two instances (repeat suppression on/off)
// driven in lockstep and compared every cycle with a sample-window model.
module tb_codificador_botones;

  localparam int DC    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       arriba, abajo, izquierda, derecha, pausa, rd_en;
  logic [2:0] cmd_s, cmd_n;
  logic       valid_s, valid_n, full_s, full_n, ovf_s, ovf_n;

  codificador_botones #(.DEBOUNCE_CYCLES(DC), .DEPTH(DEPTH), .SUPRIMIR_REPETIDOS(1'b1)) dut_s (
    .clk(clk), .rst(rst), .arriba(arriba), .abajo(abajo), .izquierda(izquierda),
    .derecha(derecha), .pausa(pausa), .rd_en(rd_en),
    .cmd(cmd_s), .cmd_valid(valid_s), .full(full_s), .overflow(ovf_s)
  );

  codificador_botones #(.DEBOUNCE_CYCLES(DC), .DEPTH(DEPTH), .SUPRIMIR_REPETIDOS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .arriba(arriba), .abajo(abajo), .izquierda(izquierda),
    .derecha(derecha), .pausa(pausa), .rd_en(rd_en),
    .cmd(cmd_n), .cmd_valid(valid_n), .full(full_n), .overflow(ovf_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: raw sample history per button, debounced level, and per instance
  // (1 = suppression on, 0 = off) a head-first list of stored codes.
  logic [31:0] sh [5];
  logic        mdb [5];
  int          mf [2][8];
  int          mcnt [2];
  int          movf [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_cmd(input int d);
    return (mcnt[d] > 0) ? mf[d][0] : 0;
  endfunction

  task automatic check_all();
    chk("cmd_s",   32'(cmd_s),   model_cmd(1));
    chk("valid_s", 32'(valid_s), (mcnt[1] > 0) ? 1 : 0);
    chk("full_s",  32'(full_s),  (mcnt[1] == DEPTH) ? 1 : 0);
    chk("ovf_s",   32'(ovf_s),   movf[1]);
    chk("cmd_n",   32'(cmd_n),   model_cmd(0));
    chk("valid_n", 32'(valid_n), (mcnt[0] > 0) ? 1 : 0);
    chk("full_n",  32'(full_n),  (mcnt[0] == DEPTH) ? 1 : 0);
    chk("ovf_n",   32'(ovf_n),   movf[0]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      sh[i]  = '0;
      mdb[i] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0;
      movf[d] = 0;
    end
  endtask

  // A debounced level flips once the synchronised sample stream (raw delayed
  // by two edges) has shown the opposite value for DC consecutive edges.
  task automatic model_edge(input logic [4:0] b, input logic rd);
    logic [4:0]    rise;
    logic [DC-1:0] win;
    int            code;
    if (!rst) begin
      model_reset();
      return;
    end
    rise = '0;
    for (int i = 0; i < 5; i++) begin
      sh[i] = {sh[i][30:0], b[i]};
      win   = sh[i][DC+1:2];
      if (!mdb[i] && (&win)) begin
        mdb[i]  = 1'b1;
        rise[i] = 1'b1;
      end else if (mdb[i] && (win == '0)) begin
        mdb[i] = 1'b0;
      end
    end
    code = rise[4] ? 5 : rise[0] ? 1 : rise[1] ? 2 : rise[2] ? 3 : rise[3] ? 4 : 0;
    for (int d = 0; d < 2; d++) begin
      int n;
      int newest;
      bit pop;
      n      = mcnt[d];
      newest = (n > 0) ? mf[d][n-1] : -1;
      pop    = rd && (n > 0);
      if (pop) begin
        for (int k = 0; k < 7; k++) mf[d][k] = mf[d][k+1];
        mcnt[d]--;
      end
      if (code != 0) begin
        if ((d == 1) && (n > 0) && (code == newest)) begin
          // repeat of newest entry: dropped silently
        end else if ((n == DEPTH) && !pop) begin
          movf[d] = 1;
        end else begin
          mf[d][mcnt[d]] = code;
          mcnt[d]++;
        end
      end
    end
  endtask

  // Called at a negedge: drive, clock, update model, check at next negedge.
  task automatic tick(input logic [4:0] b, input logic rd);
    {pausa, derecha, izquierda, abajo, arriba} = b;
    rd_en = rd;
    @(posedge clk);
    model_edge(b, rd);
    @(negedge clk);
    check_all();
  endtask

  task automatic press(input int idx);
    logic [4:0] b;
    b = 5'(1 << idx);
    repeat (DC + 3) tick(b, 1'b0);
    repeat (DC + 3) tick(5'b0, 1'b0);
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset(input logic [4:0] b);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_cmd",   32'(cmd_s),   0);
    chk("rst_valid", 32'(valid_s), 0);
    chk("rst_full",  32'(full_n),  0);
    chk("rst_ovf",   32'(ovf_n),   0);
    @(negedge clk);
    tick(b, 1'b0);
    tick(b, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    logic [2:0] drain [4];
    rst = 1'b0;
    {pausa, derecha, izquierda, abajo, arriba} = '0;
    rd_en = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    tick(5'b0, 1'b0);
    rst = 1'b1;

    // Latency: arriba raised before the first edge, code visible after the 6th.
    repeat (5) tick(5'b00001, 1'b0);
    chk("lat5_valid", 32'(valid_s), 0);
    tick(5'b00001, 1'b0);
    chk("lat6_valid", 32'(valid_s), 1);
    chk("lat6_cmd",   32'(cmd_s),   1);
    tick(5'b00001, 1'b1);
    chk("pop_cmd",    32'(cmd_s),   0);
    chk("pop_valid",  32'(valid_s), 0);
    repeat (DC + 3) tick(5'b0, 1'b0);

    // Bouncing derecha yields exactly one code 4.
    repeat (2) tick(5'b01000, 1'b0);
    repeat (2) tick(5'b00000, 1'b0);
    repeat (2) tick(5'b01000, 1'b0);
    repeat (DC + 4) tick(5'b01000, 1'b0);
    chk("bounce_cmd", 32'(cmd_s), 4);
    repeat (DC + 3) tick(5'b0, 1'b0);
    tick(5'b0, 1'b1);
    chk("bounce_one", 32'(valid_s), 0);

    // abajo + pausa together, then pausa again without popping.
    repeat (DC + 3) tick(5'b10010, 1'b0);
    repeat (DC + 3) tick(5'b0, 1'b0);
    chk("prio_cmd", 32'(cmd_s), 5);
    press(4);
    chk("dup_s_full", 32'(full_s), 0);
    repeat (2) tick(5'b0, 1'b1);

    // Fill to overflow: 1,2,3,4,1.
    press(0); press(1); press(2); press(3);
    chk("fill_full", 32'(full_n), 1);
    press(0);
    chk("fill_ovf", 32'(ovf_n), 1);
    repeat (5) tick(5'b0, 1'b1);

    // Full FIFO with a pop coincident with a new izquierda press.
    async_reset(5'b0);
    press(0); press(1); press(2); press(3);
    repeat (DC + 1) tick(5'b00100, 1'b0);
    tick(5'b00100, 1'b1);
    chk("coinc_full", 32'(full_s), 1);
    chk("coinc_ovf",  32'(ovf_s),  0);
    repeat (DC + 3) tick(5'b0, 1'b0);
    drain[0] = 3'd2; drain[1] = 3'd3; drain[2] = 3'd4; drain[3] = 3'd3;
    for (int k = 0; k < 4; k++) begin
      chk("drain", 32'(cmd_s), 32'(drain[k]));
      tick(5'b0, 1'b1);
    end

    // Reset with two entries and izquierda mid-debounce, held through release.
    press(0); press(1);
    tick(5'b00100, 1'b0);
    tick(5'b00100, 1'b0);
    async_reset(5'b00100);
    repeat (5) tick(5'b00100, 1'b0);
    chk("rel5_valid", 32'(valid_s), 0);
    tick(5'b00100, 1'b0);
    chk("rel6_cmd", 32'(cmd_s), 3);
    repeat (DC + 3) tick(5'b0, 1'b1);

    // Random segments of held button patterns with random pops.
    for (int seg = 0; seg < 250; seg++) begin
      logic [4:0] b;
      int         hold;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1, 2:    b = 5'(1 << $urandom_range(0, 4));
        default: b = 5'($urandom_range(0, 31));
      endcase
      hold = $urandom_range(1, 9);
      if ($urandom_range(0, 60) == 0) async_reset(b);
      for (int h = 0; h < hold; h++) tick(b, ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
